// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped write-back cache: default geometry,
// derived field widths and the controller state encoding.
package cache_pkg;

    localparam int C_BLOCK_SIZE = 2;
    localparam int C_LINE_SIZE  = 32;
    localparam int ADDRESS_SIZE = 32;
    localparam int C_INDEX_SIZE = 3;

    function automatic int line_width(input int block_size, input int word_w);
        return (2 ** block_size) * word_w;
    endfunction

    function automatic int tag_width(input int addr_w, input int index_w, input int block_size);
        return addr_w - index_w - block_size - 2;
    endfunction

    function automatic int mem_addr_width(input int addr_w, input int block_size);
        return addr_w - block_size - 2;
    endfunction

    localparam int LINE_W     = line_width(C_BLOCK_SIZE, C_LINE_SIZE);
    localparam int TAG_W      = tag_width(ADDRESS_SIZE, C_INDEX_SIZE, C_BLOCK_SIZE);
    localparam int MEM_ADDR_W = mem_addr_width(ADDRESS_SIZE, C_BLOCK_SIZE);
    localparam int NUM_LINES  = 2 ** C_INDEX_SIZE;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2,
        UPDATE    = 2'd3
    } cache_state_t;

endpackage

// File: rtl/cache_line_store.sv
// Line storage for the cache: data, tag, valid and dirty per line. One write
// port (word write or whole-line fill) and a combinational read port.
module cache_line_store
    import cache_pkg::*;
#(
    parameter int INDEX_W  = C_INDEX_SIZE,
    parameter int TAG_BITS = TAG_W,
    parameter int WORD_W   = C_LINE_SIZE,
    parameter int OFFSET_W = C_BLOCK_SIZE,
    parameter int LINE_BITS = line_width(OFFSET_W, WORD_W)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [INDEX_W-1:0]   rd_index,
    output logic [LINE_BITS-1:0] rd_line,
    output logic [TAG_BITS-1:0]  rd_tag,
    output logic                 rd_valid,
    output logic                 rd_dirty,
    input  logic                 wr_en,
    input  logic                 wr_fill,
    input  logic [INDEX_W-1:0]   wr_index,
    input  logic [OFFSET_W-1:0]  wr_offset,
    input  logic [WORD_W-1:0]    wr_word,
    input  logic [LINE_BITS-1:0] wr_line,
    input  logic [TAG_BITS-1:0]  wr_tag
);

    localparam int LINES = 2 ** INDEX_W;

    logic [LINE_BITS-1:0] data_q  [LINES];
    logic [TAG_BITS-1:0]  tag_q   [LINES];
    logic [LINES-1:0]     valid_q;
    logic [LINES-1:0]     dirty_q;

    // Data and tags survive reset; only the status bits are cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (wr_fill) begin
                data_q[wr_index] <= wr_line;
                tag_q[wr_index]  <= wr_tag;
            end else begin
                data_q[wr_index][int'(wr_offset) * WORD_W +: WORD_W] <= wr_word;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (wr_en) begin
            if (wr_fill) begin
                valid_q[wr_index] <= 1'b1;
                dirty_q[wr_index] <= 1'b0;
            end else begin
                dirty_q[wr_index] <= 1'b1;
            end
        end
    end

    assign rd_line  = data_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_valid = valid_q[rd_index];
    assign rd_dirty = dirty_q[rd_index];

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped write-back, write-allocate cache controller. Hits complete in the
// request cycle; misses write back a dirty victim, refill the line, then retry.
module dm_cache_ctrl
    import cache_pkg::*;
#(
    parameter int c_block_size = C_BLOCK_SIZE,
    parameter int c_line_size  = C_LINE_SIZE,
    parameter int address_size = ADDRESS_SIZE,
    parameter int c_index_size = C_INDEX_SIZE
) (
    input  logic                                                c_clk_i,
    input  logic                                                c_reset_n_i,
    input  logic                                                c_read_i,
    input  logic                                                c_wr_i,
    input  logic [address_size-1:0]                             c_addr_i,
    input  logic [c_line_size-1:0]                              c_wr_data_i,
    output logic [c_line_size-1:0]                              c_read_data_o,
    output logic                                                c_busywait_o,
    output logic                                                c_mem_read_o,
    output logic                                                c_mem_wr_o,
    output logic [mem_addr_width(address_size, c_block_size)-1:0] c_mem_addr_o,
    output logic [line_width(c_block_size, c_line_size)-1:0]    c_mem_wr_data_o,
    input  logic [line_width(c_block_size, c_line_size)-1:0]    c_mem_read_data_i,
    input  logic                                                c_mem_busywait_i
);

    localparam int LINE_BITS = line_width(c_block_size, c_line_size);
    localparam int TAG_BITS  = tag_width(address_size, c_index_size, c_block_size);
    localparam int IDX_LSB   = c_block_size + 2;
    localparam int TAG_LSB   = c_index_size + c_block_size + 2;

    cache_state_t state;
    logic         started;

    logic [TAG_BITS-1:0]     req_tag;
    logic [c_index_size-1:0] req_index;
    logic [c_block_size-1:0] req_offset;
    logic                    unused_byte_off;

    logic [TAG_BITS-1:0]     lat_tag;
    logic [c_index_size-1:0] lat_index;
    logic [LINE_BITS-1:0]    fill_line;

    logic [LINE_BITS-1:0]    rd_line;
    logic [TAG_BITS-1:0]     rd_tag;
    logic                    rd_valid;
    logic                    rd_dirty;

    logic                    request;
    logic                    hit;
    logic                    miss;
    logic                    mem_done;

    logic                    st_wr_en;
    logic                    st_wr_fill;
    logic [c_index_size-1:0] st_wr_index;

    assign req_tag         = c_addr_i[address_size-1:TAG_LSB];
    assign req_index       = c_addr_i[TAG_LSB-1:IDX_LSB];
    assign req_offset      = c_addr_i[IDX_LSB-1:2];
    assign unused_byte_off = ^c_addr_i[1:0];

    assign request  = c_read_i || c_wr_i;
    assign hit      = rd_valid && (rd_tag == req_tag);
    assign miss     = request && !hit;
    assign mem_done = started && !c_mem_busywait_i;

    // Stall is combinational so a miss is flagged in the very cycle it is presented.
    assign c_busywait_o  = c_reset_n_i && ((state != IDLE) || miss);
    assign c_read_data_o = (state == IDLE && c_read_i && hit)
                         ? rd_line[int'(req_offset) * c_line_size +: c_line_size]
                         : '0;

    assign st_wr_fill  = (state == UPDATE);
    assign st_wr_en    = st_wr_fill || (state == IDLE && c_wr_i && hit);
    assign st_wr_index = st_wr_fill ? lat_index : req_index;

    cache_line_store #(
        .INDEX_W  (c_index_size),
        .TAG_BITS (TAG_BITS),
        .WORD_W   (c_line_size),
        .OFFSET_W (c_block_size),
        .LINE_BITS(LINE_BITS)
    ) u_store (
        .clk      (c_clk_i),
        .rst_n    (c_reset_n_i),
        .rd_index (req_index),
        .rd_line  (rd_line),
        .rd_tag   (rd_tag),
        .rd_valid (rd_valid),
        .rd_dirty (rd_dirty),
        .wr_en    (st_wr_en),
        .wr_fill  (st_wr_fill),
        .wr_index (st_wr_index),
        .wr_offset(req_offset),
        .wr_word  (c_wr_data_i),
        .wr_line  (fill_line),
        .wr_tag   (lat_tag)
    );

    // Miss bookkeeping and line buffers carry no reset; they are always written before use.
    always_ff @(posedge c_clk_i) begin
        if (state == IDLE && miss) begin
            lat_tag         <= req_tag;
            lat_index       <= req_index;
            c_mem_wr_data_o <= rd_line;
        end
        if (state == FETCH && mem_done) begin
            fill_line <= c_mem_read_data_i;
        end
    end

    always_ff @(posedge c_clk_i or negedge c_reset_n_i) begin
        if (!c_reset_n_i) begin
            state        <= IDLE;
            started      <= 1'b0;
            c_mem_read_o <= 1'b0;
            c_mem_wr_o   <= 1'b0;
            c_mem_addr_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss) begin
                        started <= 1'b0;
                        if (rd_valid && rd_dirty) begin
                            state        <= WRITEBACK;
                            c_mem_wr_o   <= 1'b1;
                            c_mem_addr_o <= {rd_tag, req_index};
                        end else begin
                            state        <= FETCH;
                            c_mem_read_o <= 1'b1;
                            c_mem_addr_o <= {req_tag, req_index};
                        end
                    end
                end
                // The request is withdrawn once memory shows busy; the falling busy ends it.
                WRITEBACK: begin
                    if (!started) begin
                        if (c_mem_busywait_i) begin
                            started    <= 1'b1;
                            c_mem_wr_o <= 1'b0;
                        end
                    end else if (!c_mem_busywait_i) begin
                        state        <= FETCH;
                        started      <= 1'b0;
                        c_mem_read_o <= 1'b1;
                        c_mem_addr_o <= {lat_tag, lat_index};
                    end
                end
                FETCH: begin
                    if (!started) begin
                        if (c_mem_busywait_i) begin
                            started      <= 1'b1;
                            c_mem_read_o <= 1'b0;
                        end
                    end else if (!c_mem_busywait_i) begin
                        state   <= UPDATE;
                        started <= 1'b0;
                    end
                end
                UPDATE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Scoreboard bench for dm_cache_ctrl: a flat golden memory plus a tag/valid/dirty
// model predict hits, writebacks, fetches and read data; monitors compare.
module tb_dm_cache_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         rd, wr;
    logic [31:0]  addr, wdata, rdata;
    logic         busy;
    logic         mem_read, mem_wr;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata, mem_rdata;
    logic         mem_busy;

    dm_cache_ctrl dut (
        .c_clk_i          (clk),
        .c_reset_n_i      (rst_n),
        .c_read_i         (rd),
        .c_wr_i           (wr),
        .c_addr_i         (addr),
        .c_wr_data_i      (wdata),
        .c_read_data_o    (rdata),
        .c_busywait_o     (busy),
        .c_mem_read_o     (mem_read),
        .c_mem_wr_o       (mem_wr),
        .c_mem_addr_o     (mem_addr),
        .c_mem_wr_data_o  (mem_wdata),
        .c_mem_read_data_i(mem_rdata),
        .c_mem_busywait_i (mem_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         is_wr;
        logic [27:0]  a;
        logic [127:0] d;
    } mem_exp_t;

    // Addresses stay below 1 KiB: 8 tags x 8 indices = 64 lines of 4 words.
    logic [127:0] backing [64];
    logic [31:0]  golden  [256];
    logic         m_valid [8];
    logic         m_dirty [8];
    logic [24:0]  m_tag   [8];

    logic [31:0]  exp_rd_q [$];
    mem_exp_t     mem_q    [$];

    int checks = 0;
    int errors = 0;
    int mem_lat = 3;

    int           resp_cnt;
    int           resp_la;
    logic         resp_wr;
    logic [127:0] resp_line;
    logic         prev_rd = 1'b0;
    logic         prev_wr = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] gline(input int la);
        return {golden[la*4+3], golden[la*4+2], golden[la*4+1], golden[la*4]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = '0;
        end
        for (int la = 0; la < 64; la++)
            for (int k = 0; k < 4; k++)
                golden[la*4+k] = backing[la][k*32 +: 32];
    endtask

    // Predict the memory traffic and read result of one access and update the model.
    task automatic predict(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                           output logic hit);
        logic [2:0]  idx;
        logic [24:0] tg;
        mem_exp_t    e;
        idx = a[6:4];
        tg  = a[31:7];
        hit = m_valid[idx] && (m_tag[idx] == tg);
        if (!hit) begin
            if (m_valid[idx] && m_dirty[idx]) begin
                e.is_wr = 1'b1;
                e.a     = {m_tag[idx], idx};
                e.d     = gline(int'(m_tag[idx]) * 8 + int'(idx));
                mem_q.push_back(e);
            end
            e.is_wr = 1'b0;
            e.a     = {tg, idx};
            e.d     = '0;
            mem_q.push_back(e);
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
            m_dirty[idx] = 1'b0;
        end
        if (w) begin
            golden[a[9:2]] = d;
            m_dirty[idx]   = 1'b1;
        end else if (r) begin
            exp_rd_q.push_back(golden[a[9:2]]);
        end
    endtask

    // Called and returns at posedge+1; holds the request until the cache stops stalling.
    task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        logic hit;
        int   cycles;
        predict(r, w, a, d, hit);
        rd = r; wr = w; addr = a; wdata = d;
        @(negedge clk);
        check("hit_timing", {127'd0, busy}, {127'd0, !hit});
        cycles = 0;
        while (busy && cycles < 300) begin
            @(negedge clk);
            cycles++;
        end
        if (busy) check("busy_timeout", {127'd0, busy}, 128'd0);
        @(posedge clk);
        #1;
        rd = 1'b0; wr = 1'b0;
    endtask

    // Main memory: raises busy after a request, holds it mem_lat cycles, then commits.
    initial begin
        mem_busy  = 1'b0;
        mem_rdata = '0;
        resp_cnt  = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mem_busy = 1'b0;
                resp_cnt = 0;
            end else if (mem_busy) begin
                resp_cnt--;
                if (resp_cnt <= 0) begin
                    mem_busy = 1'b0;
                    if (resp_wr) backing[resp_la] = resp_line;
                end
            end else if (mem_read || mem_wr) begin
                resp_la   = int'(mem_addr[5:0]);
                resp_wr   = mem_wr;
                resp_line = mem_wdata;
                if (mem_read) mem_rdata = backing[resp_la];
                resp_cnt  = mem_lat;
                mem_busy  = 1'b1;
            end
        end
    end

    // Monitor: memory requests and completed reads against the scoreboard queues.
    initial begin
        mem_exp_t e;
        logic [31:0] er;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if ((mem_read && !prev_rd) || (mem_wr && !prev_wr)) begin
                    if (mem_q.size() == 0) begin
                        check("mem_unexpected", {100'd0, mem_addr}, 128'hffff_ffff);
                    end else begin
                        e = mem_q.pop_front();
                        check("mem_op_is_wr", {127'd0, mem_wr}, {127'd0, e.is_wr});
                        check("mem_addr", {100'd0, mem_addr}, {100'd0, e.a});
                        if (e.is_wr) check("wb_data", mem_wdata, e.d);
                    end
                end
                if (mem_read || mem_wr) check("busy_during_mem", {127'd0, busy}, 128'd1);
                if (rd && !wr && !busy) begin
                    if (exp_rd_q.size() == 0) begin
                        check("read_unexpected", {96'd0, rdata}, 128'hffff_ffff_ffff);
                    end else begin
                        er = exp_rd_q.pop_front();
                        check("read_data", {96'd0, rdata}, {96'd0, er});
                    end
                end
            end
            prev_rd = mem_read;
            prev_wr = mem_wr;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic hit;
        int   cycles;
        int   op;
        rst_n = 1'b0;
        rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        for (int la = 0; la < 64; la++)
            backing[la] = {$urandom, $urandom, $urandom, $urandom};
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_busywait", {127'd0, busy}, 128'd0);
        check("rst_mem_read", {127'd0, mem_read}, 128'd0);
        check("rst_mem_wr", {127'd0, mem_wr}, 128'd0);
        check("rst_mem_addr", {100'd0, mem_addr}, 128'd0);
        check("rst_read_data", {96'd0, rdata}, 128'd0);
        rst_n = 1'b1;

        access(1'b1, 1'b0, 32'h0000_0000, '0);
        access(1'b1, 1'b0, 32'h0000_0004, '0);
        access(1'b0, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF);
        access(1'b1, 1'b0, 32'h0000_0008, '0);
        mem_lat = 10;
        access(1'b1, 1'b0, 32'h0000_0080, '0);
        check("wb_word2_backing", {96'd0, backing[0][64 +: 32]}, {96'd0, 32'hDEAD_BEEF});
        access(1'b1, 1'b1, 32'h0000_0094, 32'h1234_5678);
        access(1'b1, 1'b0, 32'h0000_0094, '0);
        mem_lat = 1;
        access(1'b0, 1'b1, 32'h0000_0110, 32'hCAFE_F00D);
        access(1'b1, 1'b0, 32'h0000_0010, '0);

        // Abort a refill with reset while the fetch request is outstanding.
        mem_lat = 10;
        predict(1'b1, 1'b0, 32'h0000_0200, '0, hit);
        void'(exp_rd_q.pop_back());
        rd = 1'b1; addr = 32'h0000_0200;
        cycles = 0;
        while (!mem_read && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check("abort_reached_fetch", {127'd0, mem_read}, 128'd1);
        rst_n = 1'b0;
        #1;
        check("abort_mem_read", {127'd0, mem_read}, 128'd0);
        check("abort_mem_wr", {127'd0, mem_wr}, 128'd0);
        check("abort_busywait", {127'd0, busy}, 128'd0);
        check("abort_read_data", {96'd0, rdata}, 128'd0);
        rd = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mem_q.delete();
        exp_rd_q.delete();
        model_reset();
        rst_n = 1'b1;
        mem_lat = 2;
        access(1'b1, 1'b0, 32'h0000_0000, '0);

        for (int n = 0; n < 300; n++) begin
            mem_lat = $urandom_range(1, 6);
            op = $urandom_range(0, 3);
            access(op != 2, op >= 2, $urandom_range(0, 1023) & 32'h3fc, $urandom);
        end

        repeat (3) @(posedge clk);
        check("read_queue_drained", 128'(exp_rd_q.size()), 128'd0);
        check("mem_queue_drained", 128'(mem_q.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
